spi_master_wb: RTL

//  SPI bus master with a Wishbone-like (classic, single-cycle) bus-slave port.
//  It is the host end of the SPI link served by the TART SPI slave, and is used
//  in system benches and on host-side FPGAs. The master drives SCK, SSEL and

---
 rtl/spi_master_wb.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_wb.sv
// rtl/spi_master_wb.sv - SPI mode-0 master (MSB first) behind a classic single-cycle Wishbone-like register port
`timescale 1ns/1ps
module spi_master_wb #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 4,
    parameter int CBITS  = 3,
    parameter int DELAY  = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [1:0]       adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             ack_o,
    output logic             busy_o,
    output logic             SCK,
    output logic             SSEL,
    output logic             MOSI,
    input  logic             MISO
);

    // Only 8-bit frames are supported; this block exists so out-of-range settings stand out in elaboration.
    if (WIDTH != 8 || CLKDIV < 1 || CBITS < $clog2(CLKDIV) || DELAY < 0) begin : g_unsupported_params
    end

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [CBITS-1:0] DivLast = CBITS'(CLKDIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CBITS-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_data;
    logic [WIDTH-1:0] rd_mux;
    logic             ssel;
    logic             rx_valid;
    logic             ovr;
    logic             coll;

    logic access;
    logic wr_data;
    logic rd_data;
    logic wr_ctrl;
    logic wr_status;
    logic start;
    logic phase_end;
    logic sample;
    logic high_end;
    logic byte_done;

    assign access    = cyc_i && stb_i && !ack_o;
    assign wr_data   = access && we_i && (adr_i == 2'd0);
    assign rd_data   = access && !we_i && (adr_i == 2'd0);
    assign wr_ctrl   = access && we_i && (adr_i == 2'd1);
    assign wr_status = access && we_i && (adr_i == 2'd2);
    assign start     = wr_data && !busy_o;

    assign busy_o    = (state == LOW) || (state == HIGH);
    assign SCK       = (state == HIGH);
    // A deassert written mid-byte is held off by busy until the byte ends.
    assign SSEL      = ~(ssel | busy_o);

    assign phase_end = (cnt == DivLast);
    assign sample    = (state == LOW) && phase_end;
    assign high_end  = (state == HIGH) && phase_end;
    assign byte_done = high_end && (bit_cnt == 3'd7);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOW;
            LOW:     if (phase_end) state_nxt = HIGH;
            HIGH:    if (phase_end) state_nxt = (bit_cnt == 3'd7) ? DONE : LOW;
            DONE:    state_nxt = start ? LOW : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            MOSI     <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (busy_o) begin
                cnt <= cnt + 1'b1;
            end

            // The bit counter advances once per high phase, so it wraps 7->0 exactly on entry to DONE.
            if (high_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (start) begin
                tx_shift <= dat_i;
                MOSI     <= dat_i[WIDTH-1];
            end else if (high_end && !byte_done) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                MOSI     <= tx_shift[WIDTH-2];
            end

            if (sample) begin
                rx_shift <= {rx_shift[WIDTH-2:0], MISO};
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (adr_i)
            2'd0:    rd_mux = rx_data;
            2'd1:    rd_mux = {{(WIDTH-1){1'b0}}, ssel};
            2'd2:    rd_mux = {{(WIDTH-4){1'b0}}, coll, ovr, rx_valid, busy_o};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_o    <= 1'b0;
            dat_o    <= '0;
            ssel     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            ovr      <= 1'b0;
            coll     <= 1'b0;
        end else begin
            ack_o <= access;

            if (access && !we_i) begin
                dat_o <= rd_mux;
            end

            if (wr_ctrl) begin
                ssel <= dat_i[0];
            end

            if (wr_data && busy_o) begin
                coll <= 1'b1;
            end else if (wr_status && dat_i[3]) begin
                coll <= 1'b0;
            end

            // Later assignments win: a byte completing in the same cycle as a read or W1C prevails.
            if (wr_status && dat_i[2]) begin
                ovr <= 1'b0;
            end
            if (rd_data) begin
                rx_valid <= 1'b0;
            end
            if (byte_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid) begin
                    ovr <= 1'b1;
                end
            end
        end
    end

endmodule
